// File: rtl/serial_bit_source.sv
// serial_bit_source: parallel-to-serial stage feeding a single-bit sequence detector.
// Takes WIDTH-bit words over a valid/ready handshake and emits them one bit per
// clock. The next word can load in the last-bit cycle, so consecutive words leave
// no gap on the serial line.
//   clk       : rising-edge clock
//   rst       : synchronous, active-high reset
//   up_valid  : upstream word available on up_data
//   up_data   : parallel word, sampled only on an accepted handshake
//   up_ready  : word can be accepted this cycle (combinational)
//   ser_data  : current serial bit
//   ser_valid : ser_data carries a real word bit
//   ser_last  : ser_data is the final bit of its word
//   busy      : a word is being shifted out
module serial_bit_source #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    output logic             ser_data,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             last_bit;
    logic             accept;

    // Last-bit cycle of an in-flight word: the slot where the next word may load.
    assign last_bit = (state_q == ST_SHIFT) && (bit_cnt_q == CNT_MAX);
    assign up_ready = !rst && ((state_q == ST_IDLE) || last_bit);
    assign accept   = up_valid && up_ready;

    // Outputs decode registered state only; no path from up_* reaches them.
    assign busy      = (state_q == ST_SHIFT);
    assign ser_valid = (state_q == ST_SHIFT);
    assign ser_last  = last_bit;
    assign ser_data  = (state_q == ST_SHIFT) &&
                       (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_SHIFT;
                    shreg_d   = up_data;
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (!last_bit) begin
                    // Move the next bit toward the output end, zero-filling behind it.
                    shreg_d   = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                          : {1'b0, shreg_q[WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end else if (accept) begin
                    shreg_d   = up_data;
                    bit_cnt_d = '0;
                end else begin
                    state_d   = ST_IDLE;
                    shreg_d   = '0;
                    bit_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                shreg_d   = '0;
                bit_cnt_d = '0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: tb/tb_serial_bit_source.sv
// Bench for serial_bit_source: an MSB-first and an LSB-first instance share the
// same upstream stimulus and are compared every cycle against a word/position model.
module tb_serial_bit_source;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         up_valid;
    logic [W-1:0] up_data;

    logic m_ready, m_data, m_valid, m_last, m_busy;
    logic l_ready, l_data, l_valid, l_last, l_busy;

    always #5 clk = ~clk;

    serial_bit_source #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data),
        .up_ready(m_ready), .ser_data(m_data), .ser_valid(m_valid),
        .ser_last(m_last), .busy(m_busy)
    );

    serial_bit_source #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data),
        .up_ready(l_ready), .ser_data(l_data), .ser_valid(l_valid),
        .ser_last(l_last), .busy(l_busy)
    );

    // Model: the word in flight and the index of the bit currently on the line.
    logic         md_active = 1'b0;
    int           md_pos    = 0;
    logic [W-1:0] md_word   = '0;

    int n_pass = 0;
    int n_chk  = 0;
    bit chk_en = 1'b0;

    logic [31:0] cap_m = '0;
    logic [31:0] cap_l = '0;
    int          cap_n = 0;

    function automatic logic md_ready();
        return !rst && (!md_active || md_pos == W - 1);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            md_active <= 1'b0;
        end else if (up_valid && md_ready()) begin
            md_word   <= up_data;
            md_pos    <= 0;
            md_active <= 1'b1;
        end else if (md_active) begin
            if (md_pos == W - 1) md_active <= 1'b0;
            else                 md_pos    <= md_pos + 1;
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Per-cycle compare, sampled mid-cycle; also records the emitted bit streams.
    always @(negedge clk) begin
        if (chk_en) begin
            logic e_last, e_msb, e_lsb;
            e_last = md_active && (md_pos == W - 1);
            e_msb  = md_active && md_word[W-1-md_pos];
            e_lsb  = md_active && md_word[md_pos];
            chk("m_ready", m_ready, md_ready());
            chk("m_valid", m_valid, md_active);
            chk("m_busy",  m_busy,  md_active);
            chk("m_last",  m_last,  e_last);
            chk("m_data",  m_data,  e_msb);
            chk("l_ready", l_ready, md_ready());
            chk("l_valid", l_valid, md_active);
            chk("l_busy",  l_busy,  md_active);
            chk("l_last",  l_last,  e_last);
            chk("l_data",  l_data,  e_lsb);
            if (m_valid) begin
                cap_m = {cap_m[30:0], m_data};
                cap_l = {cap_l[30:0], l_data};
                cap_n++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cap_clr();
        cap_m = '0;
        cap_l = '0;
        cap_n = 0;
    endtask

    // Present a word and hold it until the cycle the model says it is accepted.
    task automatic send(input logic [W-1:0] w);
        int t;
        up_valid = 1'b1;
        up_data  = w;
        t = 0;
        while (!md_ready() && t < 40) begin
            cyc();
            t++;
        end
        n_chk++;
        if (t >= 40) $display("FAIL send_timeout: word %h never accepted", w);
        else         n_pass++;
        cyc();
    endtask

    initial begin
        rst      = 1'b1;
        up_valid = 1'b0;
        up_data  = '0;
        repeat (2) cyc();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_ready_lit", m_ready, 1'b0);
        cyc();
        rst = 1'b0;
        cyc();

        // Single word, MSB-first 1,1,0,0,1,1,0,0; LSB-first reversed.
        cap_clr();
        send(8'hCC);
        up_valid = 1'b0;
        repeat (10) cyc();
        chk32("cc_msb", cap_m, 32'h0000_00CC);
        chk32("cc_lsb", cap_l, 32'h0000_0033);
        chk32("cc_len", 32'(cap_n), 32'd8);

        // Back-to-back words, no gap.
        cap_clr();
        send(8'hA5);
        send(8'h3C);
        up_valid = 1'b0;
        repeat (10) cyc();
        chk32("b2b_msb", cap_m, 32'h0000_A53C);
        chk32("b2b_len", 32'(cap_n), 32'd16);

        // LSB-first 8'h01 -> 1 then seven 0s.
        cap_clr();
        send(8'h01);
        up_valid = 1'b0;
        repeat (10) cyc();
        chk32("lsb01", cap_l, 32'h0000_0080);
        chk32("msb01", cap_m, 32'h0000_0001);

        // Next word offered mid-word waits for the last-bit slot.
        cap_clr();
        send(8'h00);
        up_valid = 1'b0;
        repeat (3) cyc();
        send(8'hFF);
        up_valid = 1'b0;
        repeat (10) cyc();
        chk32("wait_msb", cap_m, 32'h0000_00FF);
        chk32("wait_len", 32'(cap_n), 32'd16);

        // Mid-word reset discards the rest of the word.
        send(8'hF0);
        up_valid = 1'b0;
        repeat (4) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_valid_lit", m_valid, 1'b0);
        chk("mrst_data_lit",  m_data,  1'b0);
        chk("mrst_busy_lit",  m_busy,  1'b0);
        chk("mrst_ready_lit", m_ready, 1'b1);
        cyc();
        cap_clr();
        send(8'h81);
        up_valid = 1'b0;
        repeat (10) cyc();
        chk32("post_rst_msb", cap_m, 32'h0000_0081);
        chk32("post_rst_len", 32'(cap_n), 32'd8);

        // Valid during reset is never accepted.
        rst      = 1'b1;
        up_valid = 1'b1;
        up_data  = 8'hAA;
        repeat (3) cyc();
        @(negedge clk);
        chk("rstv_ready_lit", m_ready, 1'b0);
        chk("rstv_valid_lit", m_valid, 1'b0);
        cyc();
        rst      = 1'b0;
        up_valid = 1'b0;
        cyc();
        @(negedge clk);
        chk("rstv_after_lit", m_valid, 1'b0);
        cyc();

        // Random traffic with occasional resets.
        repeat (400) begin
            rst      = ($urandom_range(0, 39) == 0);
            up_valid = 1'($urandom_range(0, 1));
            up_data  = W'($urandom);
            cyc();
        end
        rst      = 1'b0;
        up_valid = 1'b0;
        repeat (12) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
